// File: rtl/lcd_hd44780_responder.sv
// HD44780-class LCD controller model: display side of the 4/8-bit bus.
// Decodes the instruction subset, holds a 128-byte DDRAM and a timed busy flag.
//
// Ports:
//   clk, nrst                 clock, async active-low reset
//   rs, rw, e, db_in[3:0]     bus from initiator (DB7..DB4)
//   db_out[3:0], db_oe        read data and drive enable
//   busy                      busy flag (BF)
//   four_bit, two_line        function set state (DL inverted, N)
//   disp_on, cursor_on,
//   blink_on, inc_mode        display control D/C/B, entry mode I/D
//   ac[6:0]                   address counter
//   err_overrun, err_proto    sticky error flags
//   dbg_addr, dbg_data        debug DDRAM read port, 1-cycle latency
module lcd_hd44780_responder #(
  parameter int unsigned EXEC_CYCLES  = 4000,
  parameter int unsigned CLEAR_CYCLES = 152000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  input  logic [3:0] db_in,
  output logic [3:0] db_out,
  output logic       db_oe,
  output logic       busy,
  output logic       four_bit,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       inc_mode,
  output logic [6:0] ac,
  output logic       err_overrun,
  output logic       err_proto,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int unsigned MAXC =
    (EXEC_CYCLES > CLEAR_CYCLES) ? EXEC_CYCLES : CLEAR_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] EXEC_LD = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0] CLR_LD  = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [7:0] mem [128];

  logic          e_q, e_d;
  logic          hi_q, hi_d;
  logic [3:0]    hn_q, hn_d;
  logic          hrs_q, hrs_d;
  logic          hrw_q, hrw_d;
  logic [3:0]    rlo_q, rlo_d;
  logic [3:0]    dbo_q, dbo_d;
  logic          oe_q, oe_d;
  logic          four_q, four_d;
  logic          d_q, d_d;
  logic          c_q, c_d;
  logic          b_q, b_d;
  logic          n_q, n_d;
  logic          inc_q, inc_d;
  logic [6:0]    ac_q, ac_d;
  logic          eo_q, eo_d;
  logic          ep_q, ep_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clr_q, clr_d;
  logic [6:0]    cidx_q, cidx_d;
  logic [7:0]    dbg_q;

  logic       fall, rise, bsy, done, mism, ok;
  logic       brs, brw, wr_go, mem_we;
  logic [7:0] bval, rword;
  logic [6:0] ac_step;

  always_comb begin
    fall    = e_q & ~e;
    rise    = ~e_q & e;
    bsy     = (cnt_q != '0);
    // a byte completes on every fall in 8-bit mode,
    // on the second fall of a pair in 4-bit mode
    done    = fall & (~four_q | ~hi_q);
    mism    = four_q & ~hi_q & ((hrs_q ^ rs) | (hrw_q ^ rw));
    bval    = four_q ? {hn_q, db_in} : {db_in, 4'h0};
    brs     = four_q ? hrs_q : rs;
    brw     = four_q ? hrw_q : rw;
    ok      = done & ~mism;
    wr_go   = ok & ~brw & ~bsy;
    mem_we  = wr_go & brs;
    rword   = rs ? mem[ac_q] : {bsy, ac_q};
    ac_step = inc_q ? ac_q + 7'd1 : ac_q - 7'd1;
  end

  always_comb begin
    e_d    = e;
    hi_d   = hi_q;
    hn_d   = hn_q;
    hrs_d  = hrs_q;
    hrw_d  = hrw_q;
    rlo_d  = rlo_q;
    dbo_d  = dbo_q;
    oe_d   = oe_q;
    four_d = four_q;
    d_d    = d_q;
    c_d    = c_q;
    b_d    = b_q;
    n_d    = n_q;
    inc_d  = inc_q;
    ac_d   = ac_q;
    eo_d   = eo_q;
    ep_d   = ep_q;
    cnt_d  = bsy ? cnt_q - ONE : cnt_q;
    clr_d  = clr_q;
    cidx_d = cidx_q;

    if (clr_q) begin
      cidx_d = cidx_q + 7'd1;
      if (cidx_q == 7'h7f) clr_d = 1'b0;
    end

    if (fall & four_q & hi_q) begin
      hi_d  = 1'b0;
      hn_d  = db_in;
      hrs_d = rs;
      hrw_d = rw;
    end
    if (done & four_q) hi_d = 1'b1;
    if (done & mism)   ep_d = 1'b1;

    // whole read word is captured on the first strobe of a pair
    if (rise & rw) begin
      oe_d = 1'b1;
      if (~four_q | hi_q) begin
        rlo_d = rword[3:0];
        dbo_d = rword[7:4];
      end else begin
        dbo_d = rlo_q;
      end
    end
    if (fall) oe_d = 1'b0;

    if (ok & brw & brs) ac_d = ac_step;
    if (ok & ~brw & bsy) eo_d = 1'b1;

    if (wr_go & brs) begin
      ac_d  = ac_step;
      cnt_d = EXEC_LD;
    end

    if (wr_go & ~brs) begin
      cnt_d = EXEC_LD;
      unique casez (bval)
        8'b1???????: ac_d = bval[6:0];
        8'b01??????: begin end
        8'b001?????: begin
          n_d    = bval[3];
          four_d = ~bval[4];
          hi_d   = 1'b1;
        end
        8'b0001????: begin
          if (!bval[3])
            ac_d = bval[2] ? ac_q + 7'd1 : ac_q - 7'd1;
        end
        8'b00001???: {d_d, c_d, b_d} = bval[2:0];
        8'b000001??: inc_d = bval[1];
        8'b0000001?: begin
          ac_d  = 7'd0;
          cnt_d = CLR_LD;
        end
        8'b00000001: begin
          ac_d   = 7'd0;
          inc_d  = 1'b1;
          clr_d  = 1'b1;
          cidx_d = 7'd0;
          cnt_d  = CLR_LD;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      e_q    <= 1'b0;
      hi_q   <= 1'b1;
      hn_q   <= 4'h0;
      hrs_q  <= 1'b0;
      hrw_q  <= 1'b0;
      rlo_q  <= 4'h0;
      dbo_q  <= 4'h0;
      oe_q   <= 1'b0;
      four_q <= 1'b0;
      d_q    <= 1'b0;
      c_q    <= 1'b0;
      b_q    <= 1'b0;
      n_q    <= 1'b0;
      inc_q  <= 1'b1;
      ac_q   <= 7'd0;
      eo_q   <= 1'b0;
      ep_q   <= 1'b0;
      cnt_q  <= '0;
      clr_q  <= 1'b0;
      cidx_q <= 7'd0;
    end else begin
      e_q    <= e_d;
      hi_q   <= hi_d;
      hn_q   <= hn_d;
      hrs_q  <= hrs_d;
      hrw_q  <= hrw_d;
      rlo_q  <= rlo_d;
      dbo_q  <= dbo_d;
      oe_q   <= oe_d;
      four_q <= four_d;
      d_q    <= d_d;
      c_q    <= c_d;
      b_q    <= b_d;
      n_q    <= n_d;
      inc_q  <= inc_d;
      ac_q   <= ac_d;
      eo_q   <= eo_d;
      ep_q   <= ep_d;
      cnt_q  <= cnt_d;
      clr_q  <= clr_d;
      cidx_q <= cidx_d;
    end
  end

  // DDRAM has no reset; the clear sweep owns the write port while busy
  always_ff @(posedge clk) begin
    if (clr_q)
      mem[cidx_q] <= 8'h20;
    else if (mem_we)
      mem[ac_q] <= bval;
    dbg_q <= mem[dbg_addr];
  end

  assign db_out      = dbo_q;
  assign db_oe       = oe_q;
  assign busy        = bsy;
  assign four_bit    = four_q;
  assign disp_on     = d_q;
  assign cursor_on   = c_q;
  assign blink_on    = b_q;
  assign two_line    = n_q;
  assign inc_mode    = inc_q;
  assign ac          = ac_q;
  assign err_overrun = eo_q;
  assign err_proto   = ep_q;
  assign dbg_data    = dbg_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: directed table, hand sequences,
// and randomized bus traffic against a byte-level reference model.
module tb_lcd_hd44780_responder;

  localparam int EXEC = 20;
  localparam int CLR  = 200;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rs = 1'b0, rw = 1'b0, e = 1'b0;
  logic [3:0] db_in = 4'h0;
  logic [3:0] db_out;
  logic       db_oe, busy, four_bit, disp_on, cursor_on, blink_on;
  logic       two_line, inc_mode, err_overrun, err_proto;
  logic [6:0] ac;
  logic [6:0] dbg_addr = 7'h0;
  logic [7:0] dbg_data;

  lcd_hd44780_responder #(
    .EXEC_CYCLES (EXEC),
    .CLEAR_CYCLES(CLR)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .rs         (rs),
    .rw         (rw),
    .e          (e),
    .db_in      (db_in),
    .db_out     (db_out),
    .db_oe      (db_oe),
    .busy       (busy),
    .four_bit   (four_bit),
    .disp_on    (disp_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .two_line   (two_line),
    .inc_mode   (inc_mode),
    .ac         (ac),
    .err_overrun(err_overrun),
    .err_proto  (err_proto),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: byte-level view of the controller
  bit         m_four, m_two, m_d, m_c, m_b, m_inc, m_eo, m_ep;
  bit   [6:0] m_ac;
  logic [7:0] m_mem [128];
  int         m_end;  // busy while posedge count < m_end

  function automatic bit m_busy(input int c);
    return c < m_end;
  endfunction

  function automatic logic [7:0] mflags();
    return {m_four, m_two, m_d, m_c, m_b, m_inc, m_eo, m_ep};
  endfunction

  function automatic logic [7:0] dflags();
    return {four_bit, two_line, disp_on, cursor_on, blink_on,
            inc_mode, err_overrun, err_proto};
  endfunction

  task automatic m_reset();
    {m_four, m_two, m_d, m_c, m_b} = '0;
    m_inc = 1'b1;
    m_eo  = 1'b0;
    m_ep  = 1'b0;
    m_ac  = 7'd0;
    m_end = 0;
  endtask

  // byte executed on posedge number j
  task automatic m_write(input bit r, input logic [7:0] b, input int j);
    int dur;
    if (m_busy(j - 1)) begin
      m_eo = 1'b1;
      return;
    end
    dur = EXEC;
    if (r) begin
      m_mem[m_ac] = b;
      m_ac = m_inc ? m_ac + 7'd1 : m_ac - 7'd1;
    end else if (b == 8'h00) begin
      dur = 0;
    end else if (b >= 8'h80) begin
      m_ac = b[6:0];
    end else if (b >= 8'h40) begin
      dur = EXEC;
    end else if (b >= 8'h20) begin
      m_two  = b[3];
      m_four = !b[4];
    end else if (b >= 8'h10) begin
      if (!b[3]) m_ac = b[2] ? m_ac + 7'd1 : m_ac - 7'd1;
    end else if (b >= 8'h08) begin
      {m_d, m_c, m_b} = b[2:0];
    end else if (b >= 8'h04) begin
      m_inc = b[1];
    end else if (b >= 8'h02) begin
      m_ac = 7'd0;
      dur  = CLR;
    end else begin
      for (int k = 0; k < 128; k++) m_mem[k] = 8'h20;
      m_ac  = 7'd0;
      m_inc = 1'b1;
      dur   = CLR;
    end
    if (dur != 0) m_end = j + dur;
  endtask

  // one E strobe; rc = posedge count before rise, j = posedge of fall
  task automatic pulse(input bit r, input bit w, input logic [3:0] d,
                       output logic [3:0] q, output bit o,
                       output int rc, output int j);
    @(negedge clk);
    rc = cyc;
    rs = r; rw = w; db_in = d; e = 1'b1;
    @(negedge clk);
    o = db_oe;
    @(negedge clk);
    q = db_out;
    e = 1'b0;
    @(negedge clk);
    j = cyc;
  endtask

  task automatic send_w(input bit r, input logic [7:0] b);
    logic [3:0] q;
    bit o;
    int rc, j;
    if (m_four) begin
      pulse(r, 1'b0, b[7:4], q, o, rc, j);
      pulse(r, 1'b0, b[3:0], q, o, rc, j);
      m_write(r, b, j);
    end else begin
      pulse(r, 1'b0, b[7:4], q, o, rc, j);
      m_write(r, {b[7:4], 4'h0}, j);
    end
  endtask

  task automatic send_r(input bit r, output logic [7:0] w);
    logic [3:0] q1, q2;
    bit o1, o2;
    int rc, rc2, j;
    logic [7:0] ew;
    pulse(r, 1'b1, 4'h0, q1, o1, rc, j);
    ew = r ? m_mem[m_ac] : {m_busy(rc), m_ac};
    chk("rd_oe", o1, 1);
    chk("rd_hi", q1, ew[7:4]);
    w = {q1, 4'h0};
    if (m_four) begin
      pulse(r, 1'b1, 4'h0, q2, o2, rc2, j);
      chk("rd_oe2", o2, 1);
      chk("rd_lo", q2, ew[3:0]);
      w[3:0] = q2;
    end
    chk("rd_oe_off", db_oe, 0);
    if (r) m_ac = m_inc ? m_ac + 7'd1 : m_ac - 7'd1;
  endtask

  task automatic check_state(input string t);
    chk({t, "_ac"}, ac, m_ac);
    chk({t, "_flags"}, dflags(), mflags());
    chk({t, "_busy"}, busy, m_busy(cyc));
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < CLR + 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    busy_len(n);
    if (n >= CLR + 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles",
               busy, n);
    end
  endtask

  task automatic dbg_rd(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk);
    dbg_addr = a;
    @(negedge clk);
    v = dbg_data;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_db_out"}, db_out, 0);
    chk({t, "_db_oe"}, db_oe, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_flags"}, dflags(), 8'b0000_0100);
    chk({t, "_ac"}, ac, 0);
  endtask

  typedef struct {
    bit         r;
    logic [7:0] b;
    logic [7:0] flg;
    logic [6:0] ac;
    int         bsy;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #600000;
    $display("FAIL watchdog: time %0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w, v;
    int n, op, gap;

    // flags = {four, two, d, c, b, inc, eo, ep}
    tbl[0]  = '{0, 8'h30, 8'b0000_0100, 7'h00, EXEC};
    tbl[1]  = '{0, 8'h30, 8'b0000_0100, 7'h00, EXEC};
    tbl[2]  = '{0, 8'h30, 8'b0000_0100, 7'h00, EXEC};
    tbl[3]  = '{0, 8'h20, 8'b1000_0100, 7'h00, EXEC};
    tbl[4]  = '{0, 8'h28, 8'b1100_0100, 7'h00, EXEC};
    tbl[5]  = '{0, 8'h0F, 8'b1111_1100, 7'h00, EXEC};
    tbl[6]  = '{0, 8'h06, 8'b1111_1100, 7'h00, EXEC};
    tbl[7]  = '{0, 8'h01, 8'b1111_1100, 7'h00, CLR};
    tbl[8]  = '{0, 8'h85, 8'b1111_1100, 7'h05, EXEC};
    tbl[9]  = '{1, 8'h41, 8'b1111_1100, 7'h06, EXEC};
    tbl[10] = '{0, 8'h04, 8'b1111_1000, 7'h06, EXEC};
    tbl[11] = '{1, 8'h42, 8'b1111_1000, 7'h05, EXEC};
    tbl[12] = '{0, 8'h14, 8'b1111_1000, 7'h06, EXEC};
    tbl[13] = '{0, 8'h1C, 8'b1111_1000, 7'h06, EXEC};
    tbl[14] = '{0, 8'h00, 8'b1111_1000, 7'h06, 0};
    tbl[15] = '{0, 8'h02, 8'b1111_1000, 7'h00, CLR};
    tbl[16] = '{0, 8'h06, 8'b1111_1100, 7'h00, EXEC};
    tbl[17] = '{0, 8'h0C, 8'b1110_0100, 7'h00, EXEC};
    tbl[18] = '{0, 8'h40, 8'b1110_0100, 7'h00, EXEC};
    tbl[19] = '{0, 8'h0F, 8'b1111_1100, 7'h00, EXEC};

    for (int k = 0; k < 128; k++) m_mem[k] = 'x;
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset("reset");
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      send_w(tbl[i].r, tbl[i].b);
      chk($sformatf("tbl%0d_flags", i), dflags(), tbl[i].flg);
      chk($sformatf("tbl%0d_ac", i), ac, tbl[i].ac);
      busy_len(n);
      chk($sformatf("tbl%0d_busylen", i), n, tbl[i].bsy);
    end
    dbg_rd(7'h05, v); chk("tbl_mem05", v, 8'h41);
    dbg_rd(7'h06, v); chk("tbl_mem06", v, 8'h42);
    dbg_rd(7'h00, v); chk("tbl_mem00", v, 8'h20);

    // clear then busy-flag polling
    send_w(0, 8'h01);
    send_r(0, w);
    chk("bf_first", w, 8'h80);
    n = 0;
    while (w[7] && n < 60) begin
      send_r(0, w);
      n++;
    end
    chk("bf_cleared", w[7], 0);
    dbg_rd(7'h00, v); chk("clr_mem00", v, 8'h20);
    dbg_rd(7'h7F, v); chk("clr_mem7f", v, 8'h20);

    // last address wraps to zero; data read advances ac
    send_w(0, 8'hFF); wait_idle();
    send_w(1, 8'h41);
    chk("wrap_ac", ac, 7'h00);
    wait_idle();
    dbg_rd(7'h7F, v); chk("wrap_mem7f", v, 8'h41);
    send_w(0, 8'hFF); wait_idle();
    send_r(1, w);
    chk("wrap_read", w, 8'h41);
    chk("wrap_read_ac", ac, 7'h00);

    // write about 10 clk after a previous write is dropped
    send_w(0, 8'h90); wait_idle();
    send_w(1, 8'h55);
    repeat (2) @(negedge clk);
    send_w(1, 8'h66);
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_ac", ac, 7'h11);
    wait_idle();
    dbg_rd(7'h10, v); chk("ovr_mem10", v, 8'h55);
    dbg_rd(7'h11, v); chk("ovr_mem11", v, 8'h20);
    check_state("ovr");

    // nibble pair with mismatched RS is discarded
    begin
      logic [3:0] q;
      bit o;
      int rc, j;
      pulse(1'b1, 1'b0, 4'h4, q, o, rc, j);
      pulse(1'b0, 1'b0, 4'h1, q, o, rc, j);
    end
    m_ep = 1'b1;
    chk("proto_flag", err_proto, 1);
    check_state("proto");
    dbg_rd(7'h11, v); chk("proto_mem", v, 8'h20);
    send_w(1, 8'h37);
    check_state("proto_after");
    wait_idle();
    dbg_rd(7'h11, v); chk("proto_after_mem", v, 8'h37);

    // randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      op  = $urandom_range(0, 9);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6)
                                        : EXEC + $urandom_range(0, 4);
      repeat (gap) @(negedge clk);
      case (op)
        0, 1: send_w(1, 8'($urandom_range(0, 255)));
        2: send_w(0, 8'h80 | 8'($urandom_range(0, 127)));
        3: send_w(0, 8'h04 | 8'($urandom_range(0, 3)));
        4: send_w(0, 8'h10 | 8'($urandom_range(0, 15)));
        5: send_w(0, 8'h08 | 8'($urandom_range(0, 7)));
        6: send_r(0, w);
        7: send_r(1, w);
        8: send_w(0, 8'($urandom_range(1, 3)));
        default: send_w(0, 8'h20 | 8'($urandom_range(0, 1) * 8));
      endcase
      check_state($sformatf("rnd%0d", i));
      if (op == 8) wait_idle();
    end
    wait_idle();
    for (int k = 0; k < 128; k++) begin
      dbg_rd(7'(k), v);
      chk($sformatf("rnd_mem%0h", k), v, m_mem[k]);
    end

    // reset in the middle of a clear sweep
    send_w(0, 8'hFF); wait_idle();
    send_w(1, 8'h5A); wait_idle();
    send_w(0, 8'h01);
    repeat (20) @(negedge clk);
    nrst = 1'b0;
    m_reset();
    @(negedge clk);
    chk_reset("midclr");
    nrst = 1'b1;
    repeat (CLR + 10) @(negedge clk);
    chk("midclr_busy", busy, 0);
    dbg_rd(7'h7F, v); chk("midclr_mem7f", v, 8'h5A);
    dbg_rd(7'h00, v); chk("midclr_mem00", v, 8'h20);
    send_w(0, 8'h28);
    check_state("post8bit");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
